// File: rtl/ks_seq_pkg.sv
// Shared types and helpers for the wide Kogge-Stone add/subtract sequencer.
package ks_seq_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Word index width; kept at least 1 bit so a single-word build still has an index.
  function automatic int idx_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/ks_add32_ci.sv
// Combinational 32-bit Kogge-Stone adder with carry-in.
module ks_add32_ci (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] s,
  output logic        cout
);

  logic [31:0] g0, p0, g_pre, p_pre;
  logic [32:0] c;

  assign g0 = a & b;
  assign p0 = a ^ b;

  genvar lv;
  for (lv = 0; lv < 5; lv++) begin : g_lvl
    localparam int D = 1 << lv;
    logic [31:0] g_i, p_i, g_o, p_o;
    if (lv == 0) begin : g_first
      assign g_i = g0;
      assign p_i = p0;
    end else begin : g_next
      assign g_i = g_lvl[lv-1].g_o;
      assign p_i = g_lvl[lv-1].p_o;
    end
    // Bits below the span keep their group term (generate OR 0, propagate AND 1).
    assign g_o = g_i | (p_i & {g_i[31-D:0], {D{1'b0}}});
    assign p_o = p_i & {p_i[31-D:0], {D{1'b1}}};
  end

  assign g_pre = g_lvl[4].g_o;
  assign p_pre = g_lvl[4].p_o;

  // Carry-in folds in at the end: c[i+1] = G[i:0] | P[i:0] & cin.
  assign c    = {g_pre | (p_pre & {32{cin}}), cin};
  assign s    = p0 ^ c[31:0];
  assign cout = c[32];

endmodule

// File: rtl/ks_wide_add_seq.sv
// Word-serial wide add/subtract around one shared 32-bit Kogge-Stone adder.
// Optional signed-overflow output out_ovf is enabled by defining KS_SEQ_OVF_EN.
//
// state | meaning
// IDLE  | waiting for an operand request, in_ready high
// RUN   | adding word idx per cycle, LS word first
// DONE  | result held on out_sum/out_cout until out_ready
module ks_wide_add_seq
  import ks_seq_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [32*WORDS-1:0]   in_a,
  input  logic [32*WORDS-1:0]   in_b,
  input  logic                  in_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [32*WORDS-1:0]   out_sum,
  output logic                  out_cout,
  output logic                  busy
`ifdef KS_SEQ_OVF_EN
  ,
  output logic                  out_ovf
`endif
);

  localparam int TW = WORD_W * WORDS;
  localparam int IW = idx_width(WORDS);
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            sub_q, sub_d, carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [WORD_W-1:0] a_w, b_w, s_w;
  logic            c_w;
`ifdef KS_SEQ_OVF_EN
  logic            ovf_q, ovf_d;
`endif

  assign a_w = a_q[WORD_W*idx_q +: WORD_W];
  assign b_w = sub_q ? ~b_q[WORD_W*idx_q +: WORD_W] : b_q[WORD_W*idx_q +: WORD_W];

  ks_add32_ci u_add (
    .a    (a_w),
    .b    (b_w),
    .cin  (carry_q),
    .s    (s_w),
    .cout (c_w)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sub_d     = sub_q;
    sum_d     = sum_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
`ifdef KS_SEQ_OVF_EN
    ovf_d     = ovf_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          sub_d   = in_sub;
          idx_d   = '0;
          carry_d = in_sub;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[WORD_W*idx_q +: WORD_W] = s_w;
        carry_d = c_w;
        if (idx_q == LAST) begin
          state_d = DONE;
`ifdef KS_SEQ_OVF_EN
          // Carry into the MSB is recovered from the MSB sum bit.
          ovf_d = a_w[WORD_W-1] ^ b_w[WORD_W-1] ^ s_w[WORD_W-1] ^ c_w;
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
`ifdef KS_SEQ_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
`ifdef KS_SEQ_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign out_sum  = sum_q;
  assign out_cout = carry_q;
  assign busy     = (state_q != IDLE);
`ifdef KS_SEQ_OVF_EN
  assign out_ovf  = ovf_q;
`endif

endmodule
